mc_control: RTL and testbench
=============================

# mc_control

Multi-cycle control unit for the next-generation CPU core: a Moore state machine that sequences one RV32I instruction over 3–5 cycles through a shared memory port and a single ALU. It replaces the single-cycle `control` decoder and adds a ready/request memory handshake with configurable timeout, a sticky illegal-instruction/bus-error trap, and a retired-instruction counter. It sits between the instruction register, flag outputs of the ALU and the multi-cycle datapath muxes.

## Interface
- `MEM_TIMEOUT`, 15: max wait cycles for `mem_ready_i` per access; 0 disables timeout.
- `CNT_W`, 32: width of retired-instruction counter.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. One clock; reset is synchronous and active-high.
- `instr_i` in 32: instruction register contents (valid from DECODE onward).
- `zero_i`, `lt_i`, `ltu_i` in 1 each: ALU flags from the rs1–rs2 compare.
- `mem_ready_i` in 1: memory completes the current request this cycle.
- `mem_req_o` out 1: memory access request.
- `mem_write_o` out 1: request is a store.
- `adr_src_o` out 1: 0 = PC, 1 = ALUOut.
- `ir_write_o` out 1: latch instruction and OldPC.
- `pc_write_o` out 1: update PC from result mux.
- `reg_write_o` out 1: write rd.
- `alu_src_a_o` out `alu_a_sel`: A_PC, A_OLDPC, A_RS1, A_ZERO.
- `alu_src_b_o` out `alu_b_sel`: B_RS2, B_IMM, B_FOUR.
- `imm_src_o` out `imm_src`; `alu_ctrl_o` out `alu_op`; `load_type_o` out `load_type`; `store_type_o` out `store_type`.
- `result_src_o` out `mc_result_src`: MRES_ALUOUT, MRES_DATA, MRES_ALU.
- `instr_done_o` out 1: one-cycle pulse on the last cycle of each instruction.
- `instret_o` out `CNT_W`: retired-instruction count, wraps.
- `trap_o` out 1: sticky fault flag.
- `state_o` out `mc_state`: current state, debug only.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR_ADR, UTYPE, TRAP.
- FETCH: `mem_req_o`=1, adr=PC, A_PC+B_FOUR ADD, MRES_ALU. Stays until `mem_ready_i`; in that cycle also `ir_write_o`=1 and `pc_write_o`=1, then goes to DECODE.
- DECODE: A_OLDPC+B_IMM ADD, `imm_src`=IMM_B. This precomputes the branch/JAL target into ALUOut. Dispatch: LOAD/STORE→MEMADR, OP→EXEC_R, OPIMM→EXEC_I, BRANCH→BRANCH, JAL→JAL, JALR→JALR_ADR, LUI/AUIPC→UTYPE, anything else→TRAP.
- MEMADR: A_RS1+B_IMM (IMM_I for loads, IMM_S for stores). Goes to MEMRD or MEMWR.
- MEMRD: req, adr=ALUOut; waits for ready, then MEMWB. MEMWB: MRES_DATA, `reg_write_o`, then FETCH.
- MEMWR: req, write, adr=ALUOut; on ready goes to FETCH.
- EXEC_R/EXEC_I: A_RS1, B_RS2/B_IMM, `alu_ctrl_o` from funct3/funct7 (SUB/SRA only for R-type, or via imm[30] for shifts). Then ALUWB.
- ALUWB: MRES_ALUOUT, `reg_write_o`, then FETCH.
- BRANCH: A_RS1 B_RS2 SUB, MRES_ALUOUT. `pc_write_o` = taken: BEQ z, BNE !z, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu. Then FETCH.
- JAL: `imm_src` IMM_J in DECODE, MRES_ALUOUT, `pc_write_o`, A_OLDPC+B_FOUR. Then ALUWB.
- JALR_ADR: A_RS1+B_IMM(I) into ALUOut, then JAL state reused.
- UTYPE: A_ZERO (LUI) or A_OLDPC (AUIPC), B_IMM IMM_U. Then ALUWB.
- Illegal funct3 (load 3/6/7, store ≥3, branch 2/3, JALR ≠0) goes to TRAP.
- `load_type_o`/`store_type_o` default LD_LW/ST_SW outside memory states. `alu_ctrl_o` defaults to ALU_ADD.
- TRAP: all strobes 0, `trap_o`=1. Held until reset.

## Timing
- While `rst_i`=1: every strobe, `trap_o`, `instr_done_o` = 0; `instret_o`=0; next state FETCH; wait counter 0.
- Reset mid-instruction aborts it with no write.
- With zero-wait memory, cycles per instruction: branch 3; R/I/U/store/JAL 4; load/JALR 5. Each memory wait cycle adds 1.
- Wait counter clears on entry to any memory state. When `MEM_TIMEOUT`≠0 and the counter reaches `MEM_TIMEOUT` without ready, the next state is TRAP and no strobe fires. Ready in the same cycle as the limit wins.
- `instr_done_o` is asserted when next state = FETCH and not in reset. `instret_o` increments on the following edge and wraps 2^CNT_W−1→0.
- All outputs are a combinational Moore decode of state + `instr_i` + flags + `mem_ready_i`; no output registers.

## Structure
- `cpu_pkg` gains: `mc_state`, `alu_a_sel`, `alu_b_sel`, `mc_result_src` enums.
- Existing OP_*/F3_* constants and `alu_op`/`imm_src`/`load_type`/`store_type` are reused unchanged.
- Sub-module `ctrl_decode`: combinational funct3/funct7 → `alu_op`, `load_type`, `store_type`, plus legality flag. It is shared with the single-cycle `control`.

## Test plan
- R-ADD (0x00000033), ready tied 1 → states FETCH, DECODE, EXEC_R, ALUWB; `reg_write_o` only in ALUWB; `instr_done_o` once; `instret_o` 0→1.
- LW (f3=2) with ready delayed 3 cycles in MEMRD → 8 cycles total; MEMWB has MRES_DATA, `load_type_o`=LD_LW.
- BNE, zero_i=0 → `pc_write_o`=1 in BRANCH, 3 cycles. Same with zero_i=1 → `pc_write_o`=0.
- `MEM_TIMEOUT`=4, ready held 0 in FETCH → TRAP after 4 cycles; `trap_o`=1 and stays 1. `rst_i` pulse → FETCH, `trap_o`=0.
- Opcode 0x7F → DECODE→TRAP, no reg/mem write. SB with f3=3 → TRAP.
- `rst_i` asserted in MEMWR → no `mem_write_o` after the reset edge, FETCH next, `instret_o`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the RV32I core.
// Holds opcode/funct3 constants, the ALU/immediate/load/store selector
// enums used by both the single-cycle and multi-cycle control paths, and
// the state and mux-select enums of the multi-cycle controller.
package cpu_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_src;
  typedef enum logic [2:0] {LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU} load_type;
  typedef enum logic [1:0] {ST_SB, ST_SH, ST_SW} store_type;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R,
    EXEC_I, ALUWB, BRANCH, JAL, JALR_ADR, UTYPE, TRAP
  } mc_state;

  typedef enum logic [1:0] {A_PC, A_OLDPC, A_RS1, A_ZERO} alu_a_sel;
  typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} alu_b_sel;
  typedef enum logic [1:0] {MRES_ALUOUT, MRES_DATA, MRES_ALU} mc_result_src;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational funct3/funct7 decoder.
//   opcode   - instruction[6:0]
//   funct3   - instruction[14:12]
//   instr30  - instruction[30] (funct7[5] for R-type, imm[10] for I-type)
//   alu_ctrl - ALU operation for OP / OP-IMM
//   ld_type  - load width/sign for LOAD
//   st_type  - store width for STORE
//   legal    - opcode known and funct3 valid for it
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       instr30,
  output alu_op      alu_ctrl,
  output load_type   ld_type,
  output store_type  st_type,
  output logic       legal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    ld_type  = LD_LW;
    st_type  = ST_SW;
    legal    = 1'b0;
    case (opcode)
      OP_OP, OP_OPIMM: begin
        legal = 1'b1;
        case (funct3)
          // Immediate adds never subtract: bit 30 is an immediate bit there.
          F3_ADD:  if (opcode == OP_OP && instr30) alu_ctrl = ALU_SUB;
          F3_SLL:  alu_ctrl = ALU_SLL;
          F3_SLT:  alu_ctrl = ALU_SLT;
          F3_SLTU: alu_ctrl = ALU_SLTU;
          F3_XOR:  alu_ctrl = ALU_XOR;
          F3_SR:   alu_ctrl = instr30 ? ALU_SRA : ALU_SRL;
          F3_OR:   alu_ctrl = ALU_OR;
          F3_AND:  alu_ctrl = ALU_AND;
        endcase
      end
      OP_LOAD: begin
        legal = 1'b1;
        case (funct3)
          3'd0:    ld_type = LD_LB;
          3'd1:    ld_type = LD_LH;
          3'd2:    ld_type = LD_LW;
          3'd4:    ld_type = LD_LBU;
          3'd5:    ld_type = LD_LHU;
          default: legal   = 1'b0;
        endcase
      end
      OP_STORE: begin
        legal = 1'b1;
        case (funct3)
          3'd0:    st_type = ST_SB;
          3'd1:    st_type = ST_SH;
          3'd2:    st_type = ST_SW;
          default: legal   = 1'b0;
        endcase
      end
      OP_BRANCH: legal = (funct3[2:1] != 2'b01);
      OP_JALR:   legal = (funct3 == 3'd0);
      OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle RV32I control unit (Moore FSM).
// Sequences one instruction over 3-5 cycles plus memory wait cycles through
// a shared memory port and a single ALU.
//   clk_i, rst_i           - clock, synchronous active-high reset
//   instr_i                - instruction register (valid from DECODE on)
//   zero_i, lt_i, ltu_i    - ALU compare flags for branches
//   mem_ready_i            - memory completes the current request
//   mem_req_o/mem_write_o  - memory request / store qualifier
//   adr_src_o              - 0 = PC, 1 = ALUOut
//   ir_write_o, pc_write_o, reg_write_o - datapath write strobes
//   alu_src_a_o/_b_o, imm_src_o, alu_ctrl_o, load_type_o, store_type_o,
//   result_src_o           - datapath mux/operation selects
//   instr_done_o           - pulse on the last cycle of each instruction
//   instret_o              - retired-instruction count (wraps)
//   trap_o                 - sticky fault flag, cleared only by reset
//   state_o                - current state (debug)
module mc_control
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      instr_i,
  input  logic             zero_i,
  input  logic             lt_i,
  input  logic             ltu_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_write_o,
  output logic             adr_src_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             reg_write_o,
  output alu_a_sel         alu_src_a_o,
  output alu_b_sel         alu_src_b_o,
  output imm_src           imm_src_o,
  output alu_op            alu_ctrl_o,
  output load_type         load_type_o,
  output store_type        store_type_o,
  output mc_result_src     result_src_o,
  output logic             instr_done_o,
  output logic [CNT_W-1:0] instret_o,
  output logic             trap_o,
  output mc_state          state_o
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_TIMEOUT);

  mc_state           state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0]  instret_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  alu_op      dec_alu;
  load_type   dec_ld;
  store_type  dec_st;
  logic       dec_legal;
  logic       taken;
  logic       mem_state;
  logic       timeout;
  logic       unused_instr_bits;

  assign opcode            = instr_i[6:0];
  assign funct3            = instr_i[14:12];
  assign unused_instr_bits = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

  ctrl_decode u_decode (
    .opcode   (opcode),
    .funct3   (funct3),
    .instr30  (instr_i[30]),
    .alu_ctrl (dec_alu),
    .ld_type  (dec_ld),
    .st_type  (dec_st),
    .legal    (dec_legal)
  );

  always_comb begin
    case (funct3)
      F3_BEQ:  taken = zero_i;
      F3_BNE:  taken = !zero_i;
      F3_BLT:  taken = lt_i;
      F3_BGE:  taken = !lt_i;
      F3_BLTU: taken = ltu_i;
      F3_BGEU: taken = !ltu_i;
      default: taken = 1'b0;
    endcase
  end

  assign mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  // A ready arriving in the limit cycle still completes the access.
  assign timeout   = (MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_LIM) && !mem_ready_i;

  always_comb begin
    state_d      = state_q;
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    adr_src_o    = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = A_PC;
    alu_src_b_o  = B_RS2;
    imm_src_o    = IMM_I;
    alu_ctrl_o   = ALU_ADD;
    load_type_o  = LD_LW;
    store_type_o = ST_SW;
    result_src_o = MRES_ALUOUT;
    trap_o       = 1'b0;
    instr_done_o = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req_o    = 1'b1;
        alu_src_b_o  = B_FOUR;
        result_src_o = MRES_ALU;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = DECODE;
        end else if (timeout) begin
          mem_req_o = 1'b0;
          state_d   = TRAP;
        end
      end
      DECODE: begin
        // Branch/JAL target is precomputed into ALUOut here.
        alu_src_a_o = A_OLDPC;
        alu_src_b_o = B_IMM;
        if (opcode == OP_JAL) imm_src_o = IMM_J;
        else                  imm_src_o = IMM_B;
        if (!dec_legal) state_d = TRAP;
        else begin
          case (opcode)
            OP_LOAD, OP_STORE: state_d = MEMADR;
            OP_OP:             state_d = EXEC_R;
            OP_OPIMM:          state_d = EXEC_I;
            OP_BRANCH:         state_d = BRANCH;
            OP_JAL:            state_d = JAL;
            OP_JALR:           state_d = JALR_ADR;
            OP_LUI, OP_AUIPC:  state_d = UTYPE;
            default:           state_d = TRAP;
          endcase
        end
      end
      MEMADR: begin
        alu_src_a_o = A_RS1;
        alu_src_b_o = B_IMM;
        if (opcode == OP_STORE) begin
          imm_src_o    = IMM_S;
          store_type_o = dec_st;
          state_d      = MEMWR;
        end else begin
          load_type_o = dec_ld;
          state_d     = MEMRD;
        end
      end
      MEMRD: begin
        mem_req_o   = 1'b1;
        adr_src_o   = 1'b1;
        load_type_o = dec_ld;
        if (mem_ready_i) state_d = MEMWB;
        else if (timeout) begin
          mem_req_o = 1'b0;
          state_d   = TRAP;
        end
      end
      MEMWB: begin
        result_src_o = MRES_DATA;
        reg_write_o  = 1'b1;
        load_type_o  = dec_ld;
        state_d      = FETCH;
      end
      MEMWR: begin
        mem_req_o    = 1'b1;
        mem_write_o  = 1'b1;
        adr_src_o    = 1'b1;
        store_type_o = dec_st;
        if (mem_ready_i) state_d = FETCH;
        else if (timeout) begin
          mem_req_o   = 1'b0;
          mem_write_o = 1'b0;
          state_d     = TRAP;
        end
      end
      EXEC_R: begin
        alu_src_a_o = A_RS1;
        alu_ctrl_o  = dec_alu;
        state_d     = ALUWB;
      end
      EXEC_I: begin
        alu_src_a_o = A_RS1;
        alu_src_b_o = B_IMM;
        alu_ctrl_o  = dec_alu;
        state_d     = ALUWB;
      end
      ALUWB: begin
        reg_write_o = 1'b1;
        state_d     = FETCH;
      end
      BRANCH: begin
        alu_src_a_o = A_RS1;
        alu_ctrl_o  = ALU_SUB;
        pc_write_o  = taken;
        state_d     = FETCH;
      end
      JAL: begin
        // PC takes the target from ALUOut while the ALU forms the link value.
        alu_src_a_o = A_OLDPC;
        alu_src_b_o = B_FOUR;
        pc_write_o  = 1'b1;
        state_d     = ALUWB;
      end
      JALR_ADR: begin
        alu_src_a_o = A_RS1;
        alu_src_b_o = B_IMM;
        state_d     = JAL;
      end
      UTYPE: begin
        if (opcode == OP_LUI) alu_src_a_o = A_ZERO;
        else                  alu_src_a_o = A_OLDPC;
        alu_src_b_o = B_IMM;
        imm_src_o   = IMM_U;
        state_d     = ALUWB;
      end
      TRAP: trap_o = 1'b1;
      default: state_d = FETCH;
    endcase
    if (rst_i) begin
      mem_req_o   = 1'b0;
      mem_write_o = 1'b0;
      ir_write_o  = 1'b0;
      pc_write_o  = 1'b0;
      reg_write_o = 1'b0;
      trap_o      = 1'b0;
      state_d     = FETCH;
    end
    // Waiting in FETCH also has next state FETCH; only a real return counts.
    instr_done_o = !rst_i && (state_d == FETCH) && (state_q != FETCH);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= FETCH;
      wait_cnt_q <= '0;
      instret_q  <= '0;
    end else begin
      state_q <= state_d;
      if (instr_done_o) instret_q <= instret_q + CNT_W'(1);
      if (state_d != state_q) wait_cnt_q <= '0;
      else if (mem_state && wait_cnt_q != WAIT_LIM) wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
    end
  end

  assign instret_o = instret_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;
  import cpu_pkg::*;

  localparam int TMO = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   instr = 32'h0;
  logic          zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;
  logic          mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o;
  alu_a_sel      alu_src_a_o;
  alu_b_sel      alu_src_b_o;
  imm_src        imm_src_o;
  alu_op         alu_ctrl_o;
  load_type      load_type_o;
  store_type     store_type_o;
  mc_result_src  result_src_o;
  logic          instr_done_o, trap_o;
  logic [CW-1:0] instret_o;
  mc_state       state_o;

  mc_control #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .instr_i(instr),
    .zero_i(zero), .lt_i(lt), .ltu_i(ltu), .mem_ready_i(mem_ready),
    .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .adr_src_o(adr_src_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .imm_src_o(imm_src_o),
    .alu_ctrl_o(alu_ctrl_o), .load_type_o(load_type_o), .store_type_o(store_type_o),
    .result_src_o(result_src_o), .instr_done_o(instr_done_o), .instret_o(instret_o),
    .trap_o(trap_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  instr;
    logic         z, lt, ltu;
    int           fw, dw;      // wait cycles before ready: fetch / data access
    int           cyc, regw, memw, pcw;
    bit           trap;
    mc_result_src res;         // selects seen in the completing cycle
    load_type     ld;
    store_type    st;
    alu_op        alu;         // op seen in EXEC_R/EXEC_I/BRANCH
  } vec_t;

  vec_t    vt[22];
  vec_t    exp_q[$];
  mc_state trace[4];
  int      n_chk = 0, n_fail = 0;
  int      model_instret = 0;

  task automatic chk(input int idx, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL [%0d] %s: got %0h, expected %0h", idx, nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #1;
    chk(-1, "rst mem_req",   32'(mem_req_o),    32'd0);
    chk(-1, "rst ir_write",  32'(ir_write_o),   32'd0);
    chk(-1, "rst pc_write",  32'(pc_write_o),   32'd0);
    chk(-1, "rst reg_write", 32'(reg_write_o),  32'd0);
    chk(-1, "rst done",      32'(instr_done_o), 32'd0);
    chk(-1, "rst trap",      32'(trap_o),       32'd0);
    chk(-1, "rst instret",   32'(instret_o),    32'd0);
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk(-1, "post-rst state", 32'(state_o), 32'(FETCH));
    chk(-1, "post-rst trap",  32'(trap_o),  32'd0);
    model_instret = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int    cyc = 0, regw = 0, memw = 0, pcw = 0, waited = 0, need;
    bit    done = 1'b0;
    alu_op alu_seen = ALU_ADD;
    vec_t  e;
    chk(idx, "instret start", 32'(instret_o), 32'(model_instret % (1 << CW)));
    exp_q.push_back(v);
    instr = v.instr; zero = v.z; lt = v.lt; ltu = v.ltu;
    while (!done && cyc < 40) begin
      need = (state_o == FETCH) ? v.fw : v.dw;
      mem_ready = (state_o inside {FETCH, MEMRD, MEMWR}) && (waited >= need);
      #1;
      cyc++;
      if (reg_write_o) regw++;
      if (mem_write_o) memw++;
      if (pc_write_o)  pcw++;
      if (state_o inside {EXEC_R, EXEC_I, BRANCH}) alu_seen = alu_ctrl_o;
      if (state_o inside {FETCH, MEMRD, MEMWR}) waited = mem_ready ? 0 : waited + 1;
      if (instr_done_o || trap_o) begin
        done = 1'b1;
        e = exp_q.pop_front();
        chk(idx, "trap",      32'(trap_o),       32'(e.trap));
        chk(idx, "cycles",    32'(cyc),          32'(e.cyc));
        chk(idx, "reg_write", 32'(regw),         32'(e.regw));
        chk(idx, "mem_write", 32'(memw),         32'(e.memw));
        chk(idx, "pc_write",  32'(pcw),          32'(e.pcw));
        chk(idx, "result",    32'(result_src_o), 32'(e.res));
        chk(idx, "load_type", 32'(load_type_o),  32'(e.ld));
        chk(idx, "store_type",32'(store_type_o), 32'(e.st));
        chk(idx, "alu_ctrl",  32'(alu_seen),     32'(e.alu));
        if (instr_done_o) model_instret++;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL [%0d] completion: got none within %0d cycles, expected done or trap", idx, cyc);
      exp_q.delete();
    end
    if (done && v.trap) begin
      repeat (2) begin
        mem_ready = 1'b1;
        #1;
        chk(idx, "trap sticky",  32'(trap_o),     32'd1);
        chk(idx, "trap ir_write",32'(ir_write_o), 32'd0);
        @(posedge clk); #1;
      end
      do_reset();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          instr         z     lt    ltu  fw dw cyc rw mw pw trap  res          ld     st     alu
    vt[0]  = '{32'h00000033, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 0, 1, 1'b0, MRES_ALUOUT, LD_LW, ST_SW, ALU_ADD};
    vt[1]  = '{32'h40000033, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 0, 1, 1'b0, MRES_ALUOUT, LD_LW, ST_SW, ALU_SUB};
    vt[2]  = '{32'h40005013, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 0, 1, 1'b0, MRES_ALUOUT, LD_LW, ST_SW, ALU_SRA};
    vt[3]  = '{32'h40000013, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 0, 1, 1'b0, MRES_ALUOUT, LD_LW, ST_SW, ALU_ADD};
    vt[4]  = '{32'h00002003, 1'b0, 1'b0, 1'b0, 0, 3, 8, 1, 0, 1, 1'b0, MRES_DATA,   LD_LW, ST_SW, ALU_ADD};
    vt[5]  = '{32'h00000003, 1'b0, 1'b0, 1'b0, 2, 0, 7, 1, 0, 1, 1'b0, MRES_DATA,   LD_LB, ST_SW, ALU_ADD};
    vt[6]  = '{32'h00002023, 1'b0, 1'b0, 1'b0, 0, 0, 4, 0, 1, 1, 1'b0, MRES_ALUOUT, LD_LW, ST_SW, ALU_ADD};
    vt[7]  = '{32'h00000023, 1'b0, 1'b0, 1'b0, 0, 1, 5, 0, 2, 1, 1'b0, MRES_ALUOUT, LD_LW, ST_SB, ALU_ADD};
    vt[8]  = '{32'h00001063, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 0, 2, 1'b0, MRES_ALUOUT, LD_LW, ST_SW, ALU_SUB};
    vt[9]  = '{32'h00001063, 1'b1, 1'b0, 1'b0, 0, 0, 3, 0, 0, 1, 1'b0, MRES_ALUOUT, LD_LW, ST_SW, ALU_SUB};
    vt[10] = '{32'h00004063, 1'b0, 1'b1, 1'b0, 0, 0, 3, 0, 0, 2, 1'b0, MRES_ALUOUT, LD_LW, ST_SW, ALU_SUB};
    vt[11] = '{32'h00007063, 1'b0, 1'b0, 1'b1, 0, 0, 3, 0, 0, 1, 1'b0, MRES_ALUOUT, LD_LW, ST_SW, ALU_SUB};
    vt[12] = '{32'h0000006F, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 0, 2, 1'b0, MRES_ALUOUT, LD_LW, ST_SW, ALU_ADD};
    vt[13] = '{32'h00000067, 1'b0, 1'b0, 1'b0, 0, 0, 5, 1, 0, 2, 1'b0, MRES_ALUOUT, LD_LW, ST_SW, ALU_ADD};
    vt[14] = '{32'h00000037, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 0, 1, 1'b0, MRES_ALUOUT, LD_LW, ST_SW, ALU_ADD};
    vt[15] = '{32'h00000017, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1, 0, 1, 1'b0, MRES_ALUOUT, LD_LW, ST_SW, ALU_ADD};
    vt[16] = '{32'h00000033, 1'b0, 1'b0, 1'b0, 4, 0, 8, 1, 0, 1, 1'b0, MRES_ALUOUT, LD_LW, ST_SW, ALU_ADD};
    vt[17] = '{32'h0000007F, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 0, 1, 1'b1, MRES_ALUOUT, LD_LW, ST_SW, ALU_ADD};
    vt[18] = '{32'h00003023, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 0, 1, 1'b1, MRES_ALUOUT, LD_LW, ST_SW, ALU_ADD};
    vt[19] = '{32'h00003003, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 0, 1, 1'b1, MRES_ALUOUT, LD_LW, ST_SW, ALU_ADD};
    vt[20] = '{32'h00001067, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 0, 1, 1'b1, MRES_ALUOUT, LD_LW, ST_SW, ALU_ADD};
    vt[21] = '{32'h00002063, 1'b0, 1'b0, 1'b0, 0, 0, 3, 0, 0, 1, 1'b1, MRES_ALUOUT, LD_LW, ST_SW, ALU_ADD};
    trace = '{FETCH, DECODE, EXEC_R, ALUWB};

    do_reset();

    // R-type ADD, state by state
    instr = 32'h00000033;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 0);
      #1;
      chk(200 + i, "add state",     32'(state_o),      32'(trace[i]));
      chk(200 + i, "add reg_write", 32'(reg_write_o),  32'(i == 3));
      chk(200 + i, "add done",      32'(instr_done_o), 32'(i == 3));
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    model_instret = 1;
    chk(204, "add back to fetch", 32'(state_o), 32'(FETCH));

    for (int k = 0; k < 22; k++) run_vec(k, vt[k]);

    // Fetch never answered: five FETCH cycles (counter 0..TMO) then TRAP
    instr = 32'h00000033;
    mem_ready = 1'b0;
    for (int i = 0; i <= TMO; i++) begin
      #1;
      chk(300 + i, "tmo state", 32'(state_o), 32'(FETCH));
      chk(300 + i, "tmo trap",  32'(trap_o),  32'd0);
      @(posedge clk); #1;
    end
    chk(310, "tmo trap state", 32'(state_o),   32'(TRAP));
    chk(310, "tmo trap flag",  32'(trap_o),    32'd1);
    chk(310, "tmo no req",     32'(mem_req_o), 32'd0);
    mem_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk(311, "tmo sticky",  32'(trap_o),     32'd1);
      chk(311, "tmo no irw",  32'(ir_write_o), 32'd0);
    end
    do_reset();

    // Counter wrap at 2^CW
    for (int k = 0; k < 17; k++) run_vec(400 + k, vt[0]);
    chk(417, "instret wrapped", 32'(instret_o), 32'd1);

    // Reset while a store waits in MEMWR
    instr = 32'h00002023;
    mem_ready = 1'b1;
    #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk(500, "sw in memwr",    32'(state_o),     32'(MEMWR));
    chk(500, "sw write req",   32'(mem_write_o), 32'd1);
    rst = 1'b1;
    #1;
    chk(501, "rst gates write", 32'(mem_write_o),  32'd0);
    chk(501, "rst gates done",  32'(instr_done_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk(502, "abort state",   32'(state_o),     32'(FETCH));
    chk(502, "abort instret", 32'(instret_o),   32'd0);
    chk(502, "abort write",   32'(mem_write_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
